alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single combinational 64-bit `alu` datapath between two requesters (two issue slots / hardware threads). It round-robin arbitrates between them, registers operands, and holds them on the ALU for a per-op latency so slow multiply/divide paths can be multicycle-constrained. It captures the result and flags, keeps one architectural carry flag per requester (fed back as `cin`), and returns a response over a valid/ready handshake.

## Interface
- `MUL_LAT`, default 4: ALU cycles allowed for ops 5–8 (≥1).
- `DIV_LAT`, default 16: ALU cycles allowed for ops 9–12 (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `req_valid`  in  2  per-requester request valid; bit i = requester i.
- `req_ready`  out  2  per-requester accept.
- `req_op`  in  16  packed 2×8 ALU op; [8i+7:8i] = requester i.
- `req_a`, `req_b`  in  128 each  packed 2×64 operands.
- `req_width`  in  4  packed 2×2 width select (0=8, 1=16, 2=32, 3=64 bit).
- `alu_op`  out  8  to ALU.
- `alu_a`, `alu_b`  out  64 each  to ALU.
- `alu_cin`  out  1  to ALU.
- `alu_width`  out  2  to ALU.
- `alu_r`  in  64  from ALU.
- `alu_zero`, `alu_carry`, `alu_setcarry`, `alu_setr`  in  1 each  from ALU.
- `rsp_valid`  out  1  response valid.
- `rsp_ready`  in  1  response accept.
- `rsp_id`  out  1  requester the response belongs to.
- `rsp_r`  out  64  result.
- `rsp_zero`  out  1  zero flag.
- `rsp_wr`  out  1  writeback enable (captured `setr`).
- `rsp_dz`  out  1  divide-by-zero.
- `carry_flag`  out  2  per-requester carry flag.

## Operation
- FSM states: IDLE, EXEC, RESP. One transaction outstanding at a time.
- **IDLE:**
  - Winner is the only valid requester, or `prio` on contention.
  - `req_ready[winner]`=1, combinational from `req_valid`. Other ready bits are 0.
  - On handshake: latch op, a, b, width and id; set `prio <= ~id`; load `cnt`; go to EXEC.
- **Latency L:**
  - op[6:0] in 5–8: L=MUL_LAT.
  - op[6:0] in 9–12: L=DIV_LAT.
  - Otherwise: L=1.
  - `cnt` loads L-1.
- **Divide-by-zero:**
  - Condition: op[6:0] in 9–12 and the effective b is zero. Effective b is 0 when op[7]=1, otherwise b masked to the selected width.
  - Then L=1, `rsp_r`=0, `rsp_zero`=1, `rsp_wr`=0, `rsp_dz`=1.
  - Carry is not updated.
- **EXEC:**
  - `alu_*` outputs are driven from the latched registers. `alu_cin = carry_flag[id]`.
  - `cnt` decrements each cycle.
  - When `cnt`==0:
    - Capture `alu_r`, `alu_zero` and `alu_setr` into `rsp_*`.
    - If `alu_setcarry`, set `carry_flag[id] <= alu_carry`.
    - Go to RESP.
- **RESP:**
  - `rsp_valid`=1. All `rsp_*` are held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: go to IDLE.
  - No new request is accepted in the same cycle.
- **Request rule:** a requester holds `req_valid` and its fields stable until accepted. Dropping valid before accept is legal, and no grant results.
- **Unsupported ops:** op 15 and ≥17 pass through. The ALU yields 0, and the response is returned normally.
- **Reset (any state, including mid-EXEC/RESP):**
  - State returns to IDLE and the in-flight transaction is discarded with no response.
  - `prio`=0, `carry_flag`=0.
  - All `rsp_*` are 0. `alu_op`/`alu_a`/`alu_b`/`alu_width`/`alu_cin` are 0.
  - `req_ready` is 0 while `rst_n`=0.

## Timing
- Handshake in cycle 0. EXEC occupies cycles 1..L, with capture at the end of cycle L. `rsp_valid` asserts in cycle L+1.
- Accept-to-response latency is L+1 cycles. Response back-to-back with `rsp_ready`=1 gives a minimum of L+2 cycles per op, so single-cycle ops run at one op every 3 cycles.
- The `carry_flag` update is visible from cycle L+1. The next op from the same requester uses the updated `cin`.
- `alu_*` outputs are stable for all L EXEC cycles. Multicycle constraints of MUL_LAT/DIV_LAT apply on the ALU paths.
- Contention with both requesters valid: grants strictly alternate, starting with requester 0 after reset.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles with both `req_valid`=1 → `req_ready`=0 and all outputs 0. After release, requester 0 is granted first.
- **Add then ADC:**
  - Req0 op=3, a=0xFF, b=1, width=0 → `rsp_valid` 2 cycles after accept, `rsp_r`=0, `rsp_zero`=1, `rsp_wr`=1, `carry_flag[0]`=1.
  - Then op=14, a=1, b=1 → `rsp_r`=3, `carry_flag[0]`=0.
- **Arbitration:** both requesters valid continuously with op=1, `rsp_ready`=1 → grants alternate 0,1,0,1, accepts 3 cycles apart, `rsp_id` matches the grant order.
- **Multiply:** MUL_LAT=4, op=7, width=3, a=6, b=7 → `rsp_valid` 5 cycles after accept, `rsp_r`=42. `alu_a`/`alu_b` stable over 4 cycles.
- **Divide-by-zero:** op=11, width=0, b=0x100 → `rsp_dz`=1, `rsp_r`=0, `rsp_wr`=0, latency 2, carry unchanged. Repeat with op=0x8B → same result.
- **Backpressure and mid-op reset:**
  - `rsp_ready`=0 for 3 cycles in RESP → `rsp_*` stable and no new accept.
  - Pulse `rst_n` low during EXEC of a DIV → no response, `carry_flag`=0, next request accepted normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bundle of request, ALU and response signals shared between the arbiter (slave)
// and its requesters/ALU environment (master).
interface alu_arbiter_if;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [15:0]  req_op;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_width;

    logic [7:0]   alu_op;
    logic [63:0]  alu_a;
    logic [63:0]  alu_b;
    logic         alu_cin;
    logic [1:0]   alu_width;
    logic [63:0]  alu_r;
    logic         alu_zero;
    logic         alu_carry;
    logic         alu_setcarry;
    logic         alu_setr;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [63:0]  rsp_r;
    logic         rsp_zero;
    logic         rsp_wr;
    logic         rsp_dz;
    logic [1:0]   carry_flag;

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_width,
        input  alu_r, alu_zero, alu_carry, alu_setcarry, alu_setr,
        input  rsp_ready,
        output req_ready,
        output alu_op, alu_a, alu_b, alu_cin, alu_width,
        output rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_wr, rsp_dz, carry_flag
    );

    modport master (
        output req_valid, req_op, req_a, req_b, req_width,
        output alu_r, alu_zero, alu_carry, alu_setcarry, alu_setr,
        output rsp_ready,
        input  req_ready,
        input  alu_op, alu_a, alu_b, alu_cin, alu_width,
        input  rsp_valid, rsp_id, rsp_r, rsp_zero, rsp_wr, rsp_dz, carry_flag
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin share of one combinational ALU between two requesters, holding
// operands for a per-op latency and keeping one carry flag per requester.
module alu_arbiter #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 16
) (
    input logic         clk,
    input logic         rst_n,
    alu_arbiter_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q;
    logic               prio_q;
    logic               id_q;
    logic [7:0]         op_q;
    logic [63:0]        a_q;
    logic [63:0]        b_q;
    logic [1:0]         width_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               dz_q;
    logic [1:0]         carry_q;
    logic               rsp_valid_q;
    logic [63:0]        rsp_r_q;
    logic               rsp_zero_q;
    logic               rsp_wr_q;
    logic               rsp_dz_q;

    logic               winner;
    logic               accept;
    logic [7:0]         selOp;
    logic [63:0]        selA;
    logic [63:0]        selB;
    logic [1:0]         selWidth;
    logic [63:0]        widthMask;
    logic [63:0]        effB;
    logic               isMul;
    logic               isDiv;
    logic               divZero;
    logic [CNT_W-1:0]   cnt_d;

    // Grant and latency decode for the request that would be accepted this cycle
    always_comb begin
        winner   = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
        accept   = rst_n && (state_q == IDLE) && (|bus.req_valid);
        selOp    = winner ? bus.req_op[15:8]     : bus.req_op[7:0];
        selA     = winner ? bus.req_a[127:64]    : bus.req_a[63:0];
        selB     = winner ? bus.req_b[127:64]    : bus.req_b[63:0];
        selWidth = winner ? bus.req_width[3:2]   : bus.req_width[1:0];
        case (selWidth)
            2'd0:    widthMask = 64'h0000_0000_0000_00FF;
            2'd1:    widthMask = 64'h0000_0000_0000_FFFF;
            2'd2:    widthMask = 64'h0000_0000_FFFF_FFFF;
            default: widthMask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        effB    = selOp[7] ? 64'd0 : (selB & widthMask);
        isMul   = (selOp[6:0] >= 7'd5) && (selOp[6:0] <= 7'd8);
        isDiv   = (selOp[6:0] >= 7'd9) && (selOp[6:0] <= 7'd12);
        divZero = isDiv && (effB == 64'd0);
        if (divZero)
            cnt_d = '0;
        else if (isMul)
            cnt_d = CNT_W'(MUL_LAT - 1);
        else if (isDiv)
            cnt_d = CNT_W'(DIV_LAT - 1);
        else
            cnt_d = '0;
    end

    assign bus.req_ready = accept ? (winner ? 2'b10 : 2'b01) : 2'b00;

    // Divide-by-zero never looks at the ALU result and leaves carry untouched
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            prio_q      <= 1'b0;
            id_q        <= 1'b0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            width_q     <= '0;
            cnt_q       <= '0;
            dz_q        <= 1'b0;
            carry_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_zero_q  <= 1'b0;
            rsp_wr_q    <= 1'b0;
            rsp_dz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= selOp;
                        a_q     <= selA;
                        b_q     <= selB;
                        width_q <= selWidth;
                        id_q    <= winner;
                        prio_q  <= ~winner;
                        cnt_q   <= cnt_d;
                        dz_q    <= divZero;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt_q == '0) begin
                        if (dz_q) begin
                            rsp_r_q    <= '0;
                            rsp_zero_q <= 1'b1;
                            rsp_wr_q   <= 1'b0;
                            rsp_dz_q   <= 1'b1;
                        end else begin
                            rsp_r_q    <= bus.alu_r;
                            rsp_zero_q <= bus.alu_zero;
                            rsp_wr_q   <= bus.alu_setr;
                            rsp_dz_q   <= 1'b0;
                            if (bus.alu_setcarry)
                                carry_q[id_q] <= bus.alu_carry;
                        end
                        rsp_valid_q <= 1'b1;
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_op     = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.alu_width  = width_q;
    assign bus.alu_cin    = carry_q[id_q];
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_r      = rsp_r_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_wr     = rsp_wr_q;
    assign bus.rsp_dz     = rsp_dz_q;
    assign bus.carry_flag = carry_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a small ALU stub plus a transaction-level
// reference model of grant order, latency, divide-by-zero and per-requester carry.
module tb_alu_arbiter;
    localparam int MUL_LAT = 4;
    localparam int DIV_LAT = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_arbiter_if bus();

    alu_arbiter #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] r;
        logic        zero;
        logic        carry;
        logic        setcarry;
        logic        setr;
    } aluRes_t;

    int          checkCount = 0;
    int          failCount  = 0;
    logic        refPrio;
    logic [1:0]  refCarry;
    logic [7:0]  tbOp[2];
    logic [63:0] tbA[2];
    logic [63:0] tbB[2];
    logic [1:0]  tbW[2];
    logic [7:0]  opTable[12] = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd11,
                                 8'd14, 8'd15, 8'd17, 8'h8B, 8'h83};

    function automatic logic [63:0] maskOf(input logic [1:0] w);
        case (w)
            2'd0:    return 64'hFF;
            2'd1:    return 64'hFFFF;
            2'd2:    return 64'hFFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    // Stub ALU: 1=xor, 3=add, 14=add-with-carry, 5..8=mul, 9..12=div, else 0
    function automatic aluRes_t aluModel(input logic [7:0] op, input logic [63:0] a,
                                         input logic [63:0] b, input logic [1:0] w,
                                         input logic cin);
        aluRes_t     res;
        logic [63:0] m;
        logic [63:0] ma;
        logic [63:0] mb;
        logic [64:0] sum;
        int          nb;
        res = '0;
        m   = maskOf(w);
        ma  = a & m;
        mb  = b & m;
        nb  = 8 << w;
        sum = '0;
        case (op[6:0])
            7'd1: begin
                res.r    = ma ^ mb;
                res.setr = 1'b1;
            end
            7'd3, 7'd14: begin
                sum = {1'b0, ma} + {1'b0, mb} + {64'd0, (op[6:0] == 7'd14) ? cin : 1'b0};
                res.r        = sum[63:0] & m;
                res.carry    = sum[nb];
                res.setcarry = 1'b1;
                res.setr     = 1'b1;
            end
            7'd5, 7'd6, 7'd7, 7'd8: begin
                res.r    = (ma * mb) & m;
                res.setr = 1'b1;
            end
            7'd9, 7'd10, 7'd11, 7'd12: begin
                res.r    = (mb == 64'd0) ? 64'd0 : (ma / mb);
                res.setr = 1'b1;
            end
            default: res.r = 64'd0;
        endcase
        res.zero = (res.r == 64'd0);
        return res;
    endfunction

    aluRes_t aluOut;
    assign aluOut           = aluModel(bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_width, bus.alu_cin);
    assign bus.alu_r        = aluOut.r;
    assign bus.alu_zero     = aluOut.zero;
    assign bus.alu_carry    = aluOut.carry;
    assign bus.alu_setcarry = aluOut.setcarry;
    assign bus.alu_setr     = aluOut.setr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        checkOutput({tag, "_rsp_r"}, bus.rsp_r, 64'd0);
        checkOutput({tag, "_rsp_flags"}, 64'({bus.rsp_id, bus.rsp_zero, bus.rsp_wr, bus.rsp_dz}), 64'd0);
        checkOutput({tag, "_carry_flag"}, 64'(bus.carry_flag), 64'd0);
        checkOutput({tag, "_alu_op"}, 64'(bus.alu_op), 64'd0);
        checkOutput({tag, "_alu_a"}, bus.alu_a, 64'd0);
        checkOutput({tag, "_alu_b"}, bus.alu_b, 64'd0);
        checkOutput({tag, "_alu_wc"}, 64'({bus.alu_width, bus.alu_cin}), 64'd0);
    endtask

    // One full transaction: grant, L EXEC cycles, RESP with optional backpressure
    task automatic applyStimulus(input logic [1:0] vmask, input bit keepValid, input int readyDelay);
        logic        winner;
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  w;
        logic        cinIssue;
        bit          isDiv;
        int          lat;
        aluRes_t     exp;
        logic [63:0] expR;
        logic        expZero;
        logic        expWr;
        logic        expDz;

        bus.req_valid = vmask;
        bus.req_op    = {tbOp[1], tbOp[0]};
        bus.req_a     = {tbA[1], tbA[0]};
        bus.req_b     = {tbB[1], tbB[0]};
        bus.req_width = {tbW[1], tbW[0]};
        bus.rsp_ready = 1'b0;
        winner = (vmask == 2'b11) ? refPrio : vmask[1];
        #1;
        checkOutput("grant", 64'(bus.req_ready), winner ? 64'd2 : 64'd1);

        op = tbOp[winner];
        a  = tbA[winner];
        b  = tbB[winner];
        w  = tbW[winner];
        cinIssue = refCarry[winner];
        isDiv = (op[6:0] >= 7'd9) && (op[6:0] <= 7'd12);
        if ((op[6:0] >= 7'd5) && (op[6:0] <= 7'd8))
            lat = MUL_LAT;
        else if (isDiv)
            lat = DIV_LAT;
        else
            lat = 1;
        if (isDiv && (op[7] || ((b & maskOf(w)) == 64'd0))) begin
            lat = 1; expR = 64'd0; expZero = 1'b1; expWr = 1'b0; expDz = 1'b1;
        end else begin
            exp = aluModel(op, a, b, w, cinIssue);
            expR = exp.r; expZero = exp.zero; expWr = exp.setr; expDz = 1'b0;
            if (exp.setcarry)
                refCarry[winner] = exp.carry;
        end
        refPrio = ~winner;

        tick();
        if (!keepValid)
            bus.req_valid = 2'b00;
        for (int c = 1; c <= lat; c++) begin
            checkOutput("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
            checkOutput("exec_req_ready", 64'(bus.req_ready), 64'd0);
            checkOutput("exec_alu_op", 64'(bus.alu_op), 64'(op));
            checkOutput("exec_alu_a", bus.alu_a, a);
            checkOutput("exec_alu_b", bus.alu_b, b);
            checkOutput("exec_alu_wc", 64'({bus.alu_width, bus.alu_cin}), 64'({w, cinIssue}));
            tick();
        end
        for (int c = 0; c <= readyDelay; c++) begin
            if (c == readyDelay)
                bus.rsp_ready = 1'b1;
            checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
            checkOutput("rsp_id", 64'(bus.rsp_id), 64'(winner));
            checkOutput("rsp_r", bus.rsp_r, expR);
            checkOutput("rsp_zwd", 64'({bus.rsp_zero, bus.rsp_wr, bus.rsp_dz}), 64'({expZero, expWr, expDz}));
            checkOutput("carry_flag", 64'(bus.carry_flag), 64'(refCarry));
            checkOutput("resp_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        bus.req_valid = 2'b11;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_width = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tbOp[i] = 8'd1; tbA[i] = 64'd0; tbB[i] = 64'd0; tbW[i] = 2'd0;
        end
        refPrio  = 1'b0;
        refCarry = 2'b00;

        tick();
        tick();
        checkAllZero("reset");
        rst_n = 1'b1;

        // Add with carry-out from requester 0 wins contention right after reset
        tbOp[0] = 8'd3; tbA[0] = 64'hFF; tbB[0] = 64'd1; tbW[0] = 2'd0;
        tbOp[1] = 8'd1; tbA[1] = 64'd5;  tbB[1] = 64'd3; tbW[1] = 2'd0;
        applyStimulus(2'b11, 1'b0, 0);
        tbOp[0] = 8'd14; tbA[0] = 64'd1; tbB[0] = 64'd1;
        applyStimulus(2'b01, 1'b0, 0);

        // Multiply with response backpressure while the same requester stays valid
        tbOp[1] = 8'd7; tbA[1] = 64'd6; tbB[1] = 64'd7; tbW[1] = 2'd3;
        applyStimulus(2'b10, 1'b1, 3);

        // Divide-by-zero via masked b and via op[7]; then a real divide
        tbOp[0] = 8'd11; tbA[0] = 64'h55; tbB[0] = 64'h100; tbW[0] = 2'd0;
        applyStimulus(2'b01, 1'b0, 0);
        tbOp[0] = 8'h8B; tbB[0] = 64'd5;
        applyStimulus(2'b01, 1'b0, 1);
        tbOp[0] = 8'd11; tbA[0] = 64'd100; tbB[0] = 64'd7; tbW[0] = 2'd2;
        applyStimulus(2'b01, 1'b0, 0);

        // Set carry[1], then reset in the middle of a divide
        tbOp[1] = 8'd3; tbA[1] = 64'hFF; tbB[1] = 64'd1; tbW[1] = 2'd0;
        applyStimulus(2'b10, 1'b0, 0);
        tbOp[1] = 8'd9; tbA[1] = 64'd50; tbB[1] = 64'd5; tbW[1] = 2'd0;
        bus.req_valid = 2'b10;
        bus.req_op    = {tbOp[1], tbOp[0]};
        bus.req_a     = {tbA[1], tbA[0]};
        bus.req_b     = {tbB[1], tbB[0]};
        bus.req_width = {tbW[1], tbW[0]};
        #1;
        checkOutput("midreset_grant", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid = 2'b00;
        for (int c = 0; c < 3; c++) tick();
        checkOutput("midreset_carry_before", 64'(bus.carry_flag), 64'd2);
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        tick();
        checkAllZero("midreset");
        rst_n = 1'b1;
        bus.req_valid = 2'b00;
        refPrio  = 1'b0;
        refCarry = 2'b00;
        for (int c = 0; c < DIV_LAT + 4; c++) begin
            checkOutput("midreset_no_rsp", 64'(bus.rsp_valid), 64'd0);
            tick();
        end

        // Continuous contention: grants alternate 0,1,0,1 every 3 cycles
        tbOp[0] = 8'd1; tbA[0] = 64'hA5; tbB[0] = 64'h0F; tbW[0] = 2'd1;
        tbOp[1] = 8'd1; tbA[1] = 64'h33; tbB[1] = 64'h3C; tbW[1] = 2'd0;
        for (int i = 0; i < 4; i++)
            applyStimulus(2'b11, 1'b1, 0);
        bus.req_valid = 2'b00;

        // Randomized traffic against the reference model
        for (int i = 0; i < 25; i++) begin
            for (int s = 0; s < 2; s++) begin
                tbOp[s] = opTable[$urandom_range(0, 11)];
                tbA[s]  = {$urandom, $urandom};
                tbB[s]  = ($urandom_range(0, 3) == 0) ? 64'd0 : {32'd0, $urandom} >> $urandom_range(0, 31);
                tbW[s]  = 2'($urandom_range(0, 3));
            end
            applyStimulus(2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), $urandom_range(0, 2));
        end
        bus.req_valid = 2'b00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule
